// File: rtl/chess_move_pkg.sv
// Shared move-word layout and arbiter state encoding for the column move path.
package chess_move_pkg;

  localparam int MOVE_DW = 160;

  // Low fields of a move word
  localparam int MV_FROM_LSB  = 0;
  localparam int MV_FROM_W    = 6;
  localparam int MV_TO_LSB    = 6;
  localparam int MV_TO_W      = 6;
  localparam int MV_PIECE_LSB = 12;
  localparam int MV_PIECE_W   = 4;
  localparam int MV_PROMO_LSB = 16;
  localparam int MV_PROMO_W   = 4;
  localparam int MV_SCORE_LSB = 32;
  localparam int MV_SCORE_W   = 32;

  // Flags are packed down from the top bit; bit DW-1 marks an invalid move
  localparam int FLAG_INVALID = MOVE_DW - 1;
  localparam int FLAG_PROMOTE = MOVE_DW - 2;
  localparam int FLAG_PAWN    = MOVE_DW - 3;
  localparam int FLAG_PAWN2   = MOVE_DW - 4;
  localparam int FLAG_EP      = MOVE_DW - 5;
  localparam int FLAG_CASTLE  = MOVE_DW - 6;
  localparam int FLAG_CAPTURE = MOVE_DW - 7;

  function automatic int invalid_bit(input int dw);
    return dw - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with occupancy output; full is judged on the registered level.
module sync_fifo_sa #(
  parameter int DW    = 160,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/move_gather_arbiter.sv
// Round-robin collector draining per-square move FIFOs into one output FIFO.
// Define MOVE_FILTER_EN to drop popped words whose invalid flag (bit DW-1) is set.
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | mark finished-and-empty squares served, pick next non-empty square
// DRAIN | pop the selected square until its FIFO runs empty
// DONE  | every square served; held until start
module move_gather_arbiter
  import chess_move_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DW    = 160,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_CH-1:0]          src_done,
  input  logic [N_CH-1:0]          src_empty,
  input  logic [N_CH*DW-1:0]       src_data,
  output logic [N_CH-1:0]          src_rden,
  output logic [DW-1:0]            out_data,
  output logic                     out_empty,
  output logic                     out_full,
  input  logic                     out_rden,
  output logic [$clog2(DEPTH):0]   out_level,
  output logic [CNT_W-1:0]         move_total,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_t      state, state_nxt;
  logic [N_CH-1:0] served, served_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt, ptr, ptr_nxt, ptr_inc, sel;
  logic [N_CH-1:0] eligible, cand;
  logic            found, pop, fifo_wr, clr_total;
  logic [DW-1:0]   pop_word;

  assign eligible = src_done & ~served;
  assign cand     = eligible & ~src_empty;
  assign pop_word = src_data[int'(ptr)*DW +: DW];
  assign ptr_inc  = (int'(ptr) == N_CH - 1) ? '0 : ptr + 1'b1;

  // Walk offsets from high to low so the nearest candidate at/after rr_ptr wins
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    found = 1'b0;
    sel   = rr_ptr;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_p = PW'(idx);
      if (cand[idx_p]) begin
        found = 1'b1;
        sel   = idx_p;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    served_nxt = served;
    rr_nxt     = rr_ptr;
    ptr_nxt    = ptr;
    pop        = 1'b0;
    clr_total  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          served_nxt = '0;
          clr_total  = 1'b1;
          state_nxt  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        served_nxt = served | (eligible & src_empty);
        if (found) begin
          ptr_nxt   = sel;
          state_nxt = ST_DRAIN;
        end else if (&served_nxt) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (src_empty[ptr]) begin
          served_nxt[ptr] = 1'b1;
          rr_nxt          = ptr_inc;
          state_nxt       = ST_SCAN;
        end else begin
          pop = ~out_full;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    src_rden = '0;
    if (state == ST_DRAIN) src_rden[ptr] = pop;
  end

`ifdef MOVE_FILTER_EN
  localparam int INV_BIT = invalid_bit(DW);
  assign fifo_wr = pop & ~pop_word[INV_BIT];
`else
  assign fifo_wr = pop;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      served <= '0;
      rr_ptr <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      served <= served_nxt;
      rr_ptr <= rr_nxt;
      ptr    <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_total) begin
      move_total <= '0;
    end else if (fifo_wr && (move_total != {CNT_W{1'b1}})) begin
      move_total <= move_total + 1'b1;
    end
  end

  assign busy = (state == ST_SCAN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  sync_fifo_sa #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (pop_word),
    .rd_en   (out_rden),
    .rd_data (out_data),
    .empty   (out_empty),
    .full    (out_full),
    .level   (out_level)
  );

endmodule

// File: tb/tb_move_gather_arbiter.sv
// Directed bench for move_gather_arbiter: 8 channels, 16-bit words, 4-deep output FIFO, 3-bit counter.
module tb_move_gather_arbiter;
  localparam int N_CH  = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [N_CH-1:0]      src_done = '0;
  logic [N_CH-1:0]      src_empty;
  logic [N_CH*DW-1:0]   src_data;
  logic [N_CH-1:0]      src_rden;
  logic [DW-1:0]        out_data;
  logic                 out_empty, out_full, out_rden;
  logic [2:0]           out_level;
  logic [CNT_W-1:0]     move_total;
  logic                 busy, done;

  logic [DW-1:0] mem [N_CH][16];
  int            cnt [N_CH];
  int            head [N_CH];
  logic          src_clr = 1'b0;
  logic          sink_en = 1'b0;
  logic          man_rd  = 1'b0;
  logic          got_clr = 1'b0;
  logic [DW-1:0] got [32];
  int            got_n = 0;
  int            n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  move_gather_arbiter #(
    .N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src_done(src_done),
    .src_empty(src_empty), .src_data(src_data), .src_rden(src_rden),
    .out_data(out_data), .out_empty(out_empty), .out_full(out_full),
    .out_rden(out_rden), .out_level(out_level), .move_total(move_total),
    .busy(busy), .done(done)
  );

  // Source FIFO model: show-ahead head word, popped on src_rden
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      src_empty[i]            = (head[i] >= cnt[i]);
      src_data[i*DW +: DW]    = mem[i][head[i][3:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (src_clr) head[i] <= 0;
      else if (src_rden[i]) head[i] <= head[i] + 1;
    end
  end

  assign out_rden = man_rd | (sink_en & ~out_empty);

  always @(posedge clk) begin
    if (got_clr) got_n <= 0;
    else if (out_rden && !out_empty) begin
      got[got_n[4:0]] <= out_data;
      got_n <= got_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N_CH; i++) cnt[i] = 0;
    src_clr = 1'b1;
    step();
    src_clr = 1'b0;
  endtask

  task automatic load_ch(input int ch, input int n, input logic [DW-1:0] base);
    for (int j = 0; j < n; j++) mem[ch][j] = base + DW'(j);
    cnt[ch] = n;
  endtask

  task automatic clear_got();
    got_clr = 1'b1;
    step();
    got_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      step();
      c++;
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      cnt[i]  = 0;
      head[i] = 0;
    end

    // Reset values
    step(2);
    check("rst_rden",  32'(src_rden), 0);
    check("rst_empty", 32'(out_empty), 1);
    check("rst_full",  32'(out_full), 0);
    check("rst_level", 32'(out_level), 0);
    check("rst_total", 32'(move_total), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    reset = 1'b0;

    // 1: ch0 x3, ch5 x2, everything else done and empty
    clear_src();
    load_ch(0, 3, 16'h0000);
    load_ch(5, 2, 16'h0500);
    src_done = '1;
    sink_en  = 1'b1;
    clear_got();
    pulse_start();
    wait_done("t1_done", 40);
    step(3);
    check("t1_count", got_n, 5);
    check("t1_w0", 32'(got[0]), 32'h0000);
    check("t1_w1", 32'(got[1]), 32'h0001);
    check("t1_w2", 32'(got[2]), 32'h0002);
    check("t1_w3", 32'(got[3]), 32'h0500);
    check("t1_w4", 32'(got[4]), 32'h0501);
    check("t1_total", 32'(move_total), 5);
    check("t1_busy", 32'(busy), 0);

    // 2: all done and empty -> DONE two cycles after start
    clear_src();
    pulse_start();
    check("t2_scan_busy", 32'(busy), 1);
    check("t2_scan_done", 32'(done), 0);
    step();
    check("t2_done", 32'(done), 1);
    check("t2_total", 32'(move_total), 0);
    check("t2_rden", 32'(src_rden), 0);

    // 3: backpressure, ch2 x6 into a 4-deep FIFO
    clear_src();
    load_ch(2, 6, 16'h0200);
    sink_en = 1'b0;
    clear_got();
    pulse_start();
    begin
      int c = 0;
      while (!out_full && c < 30) begin
        step();
        c++;
      end
    end
    check("t3_full", 32'(out_full), 1);
    check("t3_level4", 32'(out_level), 4);
    check("t3_rden_blocked", 32'(src_rden), 0);
    check("t3_busy", 32'(busy), 1);
    check("t3_src_left", 32'(src_empty[2]), 0);
    man_rd = 1'b1; step();
    man_rd = 1'b0; step();
    man_rd = 1'b1; step();
    man_rd = 1'b0;
    wait_done("t3_done", 10);
    check("t3_level_end", 32'(out_level), 4);
    check("t3_total", 32'(move_total), 6);
    check("t3_reads", got_n, 2);
    sink_en = 1'b1;
    step(6);
    check("t3_count", got_n, 6);
    check("t3_w0", 32'(got[0]), 32'h0200);
    check("t3_w5", 32'(got[5]), 32'h0205);
    check("t3_drained", 32'(out_empty), 1);

    // 4: round robin with ch0 finishing late, rr pointer back at 0 after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_src();
    load_ch(0, 2, 16'h0000);
    load_ch(1, 2, 16'h0100);
    load_ch(3, 2, 16'h0300);
    src_done = 8'hFE;
    clear_got();
    pulse_start();
    step(20);
    check("t4_partial", got_n, 4);
    check("t4_waiting_busy", 32'(busy), 1);
    check("t4_waiting_done", 32'(done), 0);
    check("t4_waiting_rden", 32'(src_rden), 0);
    src_done = '1;
    wait_done("t4_done", 30);
    step(3);
    check("t4_count", got_n, 6);
    check("t4_w0", 32'(got[0]), 32'h0100);
    check("t4_w1", 32'(got[1]), 32'h0101);
    check("t4_w2", 32'(got[2]), 32'h0300);
    check("t4_w3", 32'(got[3]), 32'h0301);
    check("t4_w4", 32'(got[4]), 32'h0000);
    check("t4_w5", 32'(got[5]), 32'h0001);
    check("t4_total", 32'(move_total), 6);

    // 5: reset in DRAIN with two words buffered, then clean restart
    clear_src();
    load_ch(7, 5, 16'h0700);
    sink_en = 1'b0;
    clear_got();
    pulse_start();
    begin
      int c = 0;
      while (out_level != 3'd2 && c < 20) begin
        step();
        c++;
      end
    end
    check("t5_level2", 32'(out_level), 2);
    check("t5_draining", 32'(busy), 1);
    reset = 1'b1;
    step();
    check("t5_rst_empty", 32'(out_empty), 1);
    check("t5_rst_level", 32'(out_level), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_rden", 32'(src_rden), 0);
    check("t5_rst_total", 32'(move_total), 0);
    reset = 1'b0;
    clear_src();
    load_ch(7, 5, 16'h0700);
    sink_en = 1'b1;
    clear_got();
    pulse_start();
    wait_done("t5_done", 40);
    step(3);
    check("t5_count", got_n, 5);
    check("t5_w0", 32'(got[0]), 32'h0700);
    check("t5_w4", 32'(got[4]), 32'h0704);
    check("t5_total", 32'(move_total), 5);

    // Counter saturation: 9 words against a 3-bit counter
    clear_src();
    load_ch(6, 9, 16'h0600);
    clear_got();
    pulse_start();
    wait_done("sat_done", 60);
    step(3);
    check("sat_total", 32'(move_total), 7);
    check("sat_count", got_n, 9);
    check("sat_w8", 32'(got[8]), 32'h0608);

    // 6: invalid-flagged word in the middle of ch4
    clear_src();
    mem[4][0] = 16'h0400;
    mem[4][1] = 16'h8401;
    mem[4][2] = 16'h0402;
    cnt[4]    = 3;
    clear_got();
    pulse_start();
    wait_done("t6_done", 40);
    step(3);
    check("t6_all_popped", 32'(src_empty[4]), 1);
    check("t6_w0", 32'(got[0]), 32'h0400);
`ifdef MOVE_FILTER_EN
    check("t6_count", got_n, 2);
    check("t6_total", 32'(move_total), 2);
    check("t6_w1", 32'(got[1]), 32'h0402);
`else
    check("t6_count", got_n, 3);
    check("t6_total", 32'(move_total), 3);
    check("t6_w1", 32'(got[1]), 32'h8401);
    check("t6_w2", 32'(got[2]), 32'h0402);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
